// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 32-bit integer ALU for the processor datapath.
//
// Performs add/sub, bitwise AND/ORR/EOR, a 32x32 low-word multiply and 64-bit
// signed/unsigned long multiplies. All outputs are registered, so results
// appear one rising edge after the operands are sampled. The ALU accepts a new
// operation on every cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous reset, active-low (0 clears all outputs)
//   ALUControl   operation select (see OP_* below)
//   A, B         operands
//   ALUFlags     {N,Z,C,V}, registered
//   Result       primary result / low product word, registered
//   ResultExtra  high product word for SMULL/UMULL, else 0, registered
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUFlags,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultExtra
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_ORR   = 3'b011;
  localparam logic [2:0] OP_EOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b110;
  localparam logic [2:0] OP_UMULL = 3'b111;

  // True when every bit of a double-width word is clear.
  function automatic logic is_zero(input logic [2*WIDTH-1:0] v);
    return ~(|v);
  endfunction

  // Adder path: subtraction reuses the adder as A + ~B + 1, so the carry out
  // is the "no borrow" indication directly.
  logic             cin_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH:0]   sum_s;

  assign cin_s  = (ALUControl == OP_SUB);
  assign b_op_s = cin_s ? ~B : B;
  assign sum_s  = {1'b0, A} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};

  // Multiplier path: a signed product's low 2*WIDTH bits equal the unsigned
  // product of the sign-extended operands, so one plain multiplier serves both.
  logic [2*WIDTH-1:0] sa_s, sb_s, sprod_s, uprod_s;

  assign sa_s    = {{WIDTH{A[WIDTH-1]}}, A};
  assign sb_s    = {{WIDTH{B[WIDTH-1]}}, B};
  assign sprod_s = sa_s * sb_s;
  assign uprod_s = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  logic [WIDTH-1:0] res_s, ext_s;
  logic             n_s, z_s, c_s, v_s;
  logic             long_s;

  // Next-state result, high word and flags for the selected operation.
  always_comb begin
    res_s  = {WIDTH{1'b0}};
    ext_s  = {WIDTH{1'b0}};
    c_s    = 1'b0;
    v_s    = 1'b0;
    long_s = 1'b0;
    n_s    = 1'b0;
    z_s    = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        // Overflow: effective operands share a sign that the sum does not.
        v_s   = (A[WIDTH-1] == b_op_s[WIDTH-1]) &&
                (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: res_s = A & B;
      OP_ORR: res_s = A | B;
      OP_EOR: res_s = A ^ B;
      OP_MUL: res_s = uprod_s[WIDTH-1:0];
      OP_SMULL: begin
        res_s  = sprod_s[WIDTH-1:0];
        ext_s  = sprod_s[2*WIDTH-1:WIDTH];
        long_s = 1'b1;
      end
      OP_UMULL: begin
        res_s  = uprod_s[WIDTH-1:0];
        ext_s  = uprod_s[2*WIDTH-1:WIDTH];
        long_s = 1'b1;
      end
      default: begin
        res_s  = {WIDTH{1'b0}};
        ext_s  = {WIDTH{1'b0}};
        long_s = 1'b0;
      end
    endcase
    // Long multiplies report N/Z over the full 64-bit product.
    if (long_s) begin
      n_s = ext_s[WIDTH-1];
      z_s = is_zero({ext_s, res_s});
    end else begin
      n_s = res_s[WIDTH-1];
      z_s = is_zero({{WIDTH{1'b0}}, res_s});
    end
  end

  logic [WIDTH-1:0] res_r, ext_r;
  logic [3:0]       flags_r;

  // Output registers; reset clears them immediately, independent of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_r   <= {WIDTH{1'b0}};
      ext_r   <= {WIDTH{1'b0}};
      flags_r <= 4'b0000;
    end else begin
      res_r   <= res_s;
      ext_r   <= ext_s;
      flags_r <= {n_s, z_s, c_s, v_s};
    end
  end

  assign Result      = res_r;
  assign ResultExtra = ext_r;
  assign ALUFlags    = flags_r;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu. Each directed step drives operands on
// the falling edge, pushes the expected outputs onto a scoreboard queue, and
// pops/compares one step later, #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu;

  typedef struct {
    logic [31:0] res;
    logic [31:0] ext;
    logic [3:0]  flg;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [2:0]  ALUControl;
  logic [31:0] A, B;
  logic [3:0]  ALUFlags;
  logic [31:0] Result, ResultExtra;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .ALUControl  (ALUControl),
    .A           (A),
    .B           (B),
    .ALUFlags    (ALUFlags),
    .Result      (Result),
    .ResultExtra (ResultExtra)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: 64-bit longint arithmetic, range-based overflow.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa, sbv, s;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [32:0] w;
    logic c, v, lng;
    sa = $signed(a); sbv = $signed(b); ua = a; ub = b;
    e.res = 32'h0; e.ext = 32'h0; c = 1'b0; v = 1'b0; lng = 1'b0; p = 64'h0;
    case (op)
      3'b000: begin
        w = {1'b0, a} + {1'b0, b}; e.res = w[31:0]; c = w[32];
        s = sa + sbv; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b001: begin
        e.res = a - b; c = (a >= b);
        s = sa - sbv; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b100: e.res = a ^ b;
      3'b101: begin p = ua * ub; e.res = p[31:0]; end
      3'b110: begin p = sa * sbv; e.res = p[31:0]; e.ext = p[63:32]; lng = 1'b1; end
      default: begin p = ua * ub; e.res = p[31:0]; e.ext = p[63:32]; lng = 1'b1; end
    endcase
    if (lng) e.flg = {p[63], p == 64'h0, 1'b0, 1'b0};
    else     e.flg = {e.res[31], e.res == 32'h0, c, v};
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard: empty queue, expected one entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks += 3;
      assert (Result === e.res) else begin
        errors++;
        $error("FAIL %s Result: got %h expected %h", tag, Result, e.res);
      end
      assert (ResultExtra === e.ext) else begin
        errors++;
        $error("FAIL %s ResultExtra: got %h expected %h", tag, ResultExtra, e.ext);
      end
      assert (ALUFlags === e.flg) else begin
        errors++;
        $error("FAIL %s ALUFlags: got %b expected %b", tag, ALUFlags, e.flg);
      end
    end
  endtask

  task automatic push(input logic [31:0] r, input logic [31:0] x, input logic [3:0] f);
    exp_t e;
    e.res = r; e.ext = x; e.flg = f;
    sb.push_back(e);
  endtask

  // Drive one operation at the falling edge, check it after the next rising edge.
  task automatic step(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r,
                      input logic [31:0] x, input logic [3:0] f);
    @(negedge clk);
    ALUControl = op; A = a; B = b;
    push(r, x, f);
    @(posedge clk); #1;
    check_out(tag);
  endtask

  initial begin
    reset = 1'b0; ALUControl = 3'b000; A = 32'd5; B = 32'd7;

    // Held in reset: edges must not load the 5+7 result.
    push(32'h0, 32'h0, 4'b0000);
    @(posedge clk); #1; check_out("reset_hold1");
    push(32'h0, 32'h0, 4'b0000);
    @(posedge clk); #1; check_out("reset_hold2");

    // Release: first edge with reset high produces 12.
    @(negedge clk); reset = 1'b1;
    push(32'd12, 32'h0, 4'b0000);
    @(posedge clk); #1; check_out("reset_release");

    step("smull_neg",  3'b110, 32'hFFFFFFD3, 32'd23, 32'hFFFFFBF5, 32'hFFFFFFFF, 4'b1000);
    step("umull_max",  3'b111, 32'hFFFFFFFF, 32'd2,  32'hFFFFFFFE, 32'h00000001, 4'b0000);
    step("umull_zero", 3'b111, 32'h0,        32'd2,  32'h0,        32'h0,        4'b0100);
    step("add_ovf",    3'b000, 32'h7FFFFFFF, 32'd1,  32'h80000000, 32'h0,        4'b1001);
    step("add_carry",  3'b000, 32'hFFFFFFFF, 32'd1,  32'h0,        32'h0,        4'b0110);
    step("sub_eq",     3'b001, 32'd5,        32'd5,  32'h0,        32'h0,        4'b0110);
    step("sub_borrow", 3'b001, 32'd3,        32'd5,  32'hFFFFFFFE, 32'h0,        4'b1000);
    step("and",        3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,  4'b0000);
    step("orr",        3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0,  4'b1000);
    step("eor",        3'b100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 32'h0,  4'b1000);
    step("mul_wrap",   3'b101, 32'h00010000, 32'h00010000, 32'h0,        32'h0,  4'b0100);
    step("sub_vflag",  3'b001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 32'h0, 4'b0011);

    // Mid-stream reset: asynchronous clear, and the operation sampled while
    // reset is low is discarded.
    step("pre_reset",  3'b000, 32'd100, 32'd23, 32'd123, 32'h0, 4'b0000);
    @(negedge clk);
    ALUControl = 3'b111; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    #2 reset = 1'b0;
    #1;
    checks++;
    assert (Result === 32'h0 && ResultExtra === 32'h0 && ALUFlags === 4'b0000) else begin
      errors++;
      $error("FAIL async_clear: got %h/%h/%b expected 0/0/0000", Result, ResultExtra, ALUFlags);
    end
    push(32'h0, 32'h0, 4'b0000);
    @(posedge clk); #1; check_out("reset_discard");
    @(negedge clk); reset = 1'b1;
    step("post_reset", 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1000);

    // Model-checked sweep over all opcodes with pseudo-random operands.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      exp_t e;
      op = i[2:0];
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      e = model(op, a, b);
      step($sformatf("rand%0d_op%0d", i, op), op, a, b, e.res, e.ext, e.flg);
    end

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
